pipe_in_pack_w32_r256: RTL and testbench

Width-up converter for the host-to-chip path. It packs 32-bit pipe-in words into 256-bit words and buffers them in a small internal FIFO for the 256-bit consumer. It is the write-side counterpart of the 256-to-32 debug read path: lane 0, the first 32-bit word, lands in bits [255:224]. Single clock domain; any CDC happens upstream.

---
 rtl/pipe_in_pack_w32_r256_if.sv | 27 ++
 rtl/pipe_in_pack_w32_r256.sv | 98 +++++++++
 tb/tb_pipe_in_pack_w32_r256.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_in_pack_w32_r256_if.sv
// Pipe-in 32-bit write side and 256-bit FIFO read side of the width-up packer.
interface pipe_in_pack_w32_r256_if #(
   parameter int DEPTH = 4
) ();
   logic [31:0]            din;
   logic                   wr_en;
   logic                   flush;
   logic                   rd_en;
   logic [255:0]           dout;
   logic                   valid;
   logic                   full;
   logic                   empty;
   logic                   prog_full;
   logic [$clog2(DEPTH):0] count;
   logic [2:0]             lanes;
   logic                   overflow;

   modport master (
      output din, wr_en, flush, rd_en,
      input  dout, valid, full, empty, prog_full, count, lanes, overflow
   );

   modport slave (
      input  din, wr_en, flush, rd_en,
      output dout, valid, full, empty, prog_full, count, lanes, overflow
   );
endinterface

// File: rtl/pipe_in_pack_w32_r256.sv
// Packs 32-bit words (lane 0 at [255:224]) into 256-bit FIFO entries; read data one clock after rd_en.
// Writes are dropped (sticky overflow) only when a commit would be needed while the FIFO is full.
module pipe_in_pack_w32_r256 #(
   parameter int DEPTH     = 4,
   parameter int PROG_FULL = 3
) (
   input logic                    clk,
   input logic                    rstn,
   pipe_in_pack_w32_r256_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]    r_wr_ptr;
   logic [AW:0]    r_rd_ptr;
   logic [255:0]   r_mem [DEPTH];
   logic [255:0]   r_asm;
   logic [255:0]   r_dout;
   logic [2:0]     r_lanes;
   logic           r_valid;
   logic           r_overflow;

   logic [AW:0]    w_count;
   logic           w_fifo_full;
   logic           w_empty;
   logic           w_full;
   logic           w_wr_acc;
   logic           w_push_normal;
   logic           w_push_flush;
   logic           w_push;
   logic           w_pop;
   logic [255:0]   w_asm_next;

   assign w_count     = r_wr_ptr - r_rd_ptr;
   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_fifo_full = (w_count == (AW+1)'(DEPTH));
   // Only a write or flush that needs a commit is blocked by a full FIFO.
   assign w_full      = w_fifo_full && ((r_lanes == 3'd7) || bus.flush);

   assign w_wr_acc      = bus.wr_en && !w_full;
   assign w_push_normal = w_wr_acc && (r_lanes == 3'd7);
   assign w_push_flush  = bus.flush && ((r_lanes != 3'd0) || w_wr_acc) && !w_fifo_full;
   assign w_push        = w_push_normal || w_push_flush;
   assign w_pop         = bus.rd_en && !w_empty;

   always_comb begin
      w_asm_next = r_asm;
      for (int i = 0; i < 8; i++) begin
         if (w_wr_acc && (r_lanes == 3'(i))) begin
            w_asm_next[255-32*i -: 32] = bus.din;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_asm      <= '0;
         r_lanes    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_dout     <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_asm    <= '0;
            r_lanes  <= '0;
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end else if (w_wr_acc) begin
            r_asm    <= w_asm_next;
            r_lanes  <= r_lanes + 3'd1;
         end
         if (w_pop) begin
            r_dout   <= r_mem[r_rd_ptr[AW-1:0]];
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_valid <= w_pop;
         if (bus.wr_en && w_full) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= w_asm_next;
      end
   end

   assign bus.dout      = r_dout;
   assign bus.valid     = r_valid;
   assign bus.full      = w_full;
   assign bus.empty     = w_empty;
   assign bus.prog_full = (w_count >= (AW+1)'(PROG_FULL));
   assign bus.count     = w_count;
   assign bus.lanes     = r_lanes;
   assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_pipe_in_pack_w32_r256.sv
// Directed bench for the 32-to-256 packer with DEPTH=4, PROG_FULL=3.
module tb_pipe_in_pack_w32_r256;
   logic clk = 1'b0;
   logic rstn;
   int   checks   = 0;
   int   failures = 0;

   pipe_in_pack_w32_r256_if #(.DEPTH(4)) bus ();

   pipe_in_pack_w32_r256 #(.DEPTH(4), .PROG_FULL(3)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [31:0] d);
      bus.din   = d;
      bus.wr_en = 1'b1;
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic read();
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
   endtask

   function automatic logic [255:0] pack8(input logic [31:0] b);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[255-32*i -: 32] = b + 32'(i);
      return r;
   endfunction

   initial begin
      logic [255:0] exp;
      bus.din   = '0;
      bus.wr_en = 1'b0;
      bus.flush = 1'b0;
      bus.rd_en = 1'b0;
      rstn      = 1'b0;
      tick();
      tick();
      chk("rst_count", bus.count, 0);
      chk("rst_empty", bus.empty, 1);
      chk("rst_full", bus.full, 0);
      chk("rst_pfull", bus.prog_full, 0);
      chk("rst_lanes", bus.lanes, 0);
      chk("rst_ovf", bus.overflow, 0);
      chk("rst_valid", bus.valid, 0);
      chk("rst_dout", bus.dout, 0);
      rstn = 1'b1;
      tick();

      // basic pack
      for (int k = 1; k <= 8; k++) begin
         write(32'(k));
         chk("pack_lanes", bus.lanes, k % 8);
      end
      chk("pack_empty", bus.empty, 0);
      chk("pack_count", bus.count, 1);
      read();
      chk("pack_valid", bus.valid, 1);
      chk("pack_dout", bus.dout, 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008);
      tick();
      chk("pack_valid_drop", bus.valid, 0);
      chk("pack_empty2", bus.empty, 1);

      // flush padding
      write(32'hAAAAAAAA);
      write(32'hBBBBBBBB);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("flush_count", bus.count, 1);
      chk("flush_lanes", bus.lanes, 0);
      read();
      chk("flush_dout", bus.dout, {32'hAAAAAAAA, 32'hBBBBBBBB, 192'h0});
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk("flush_noop_count", bus.count, 0);

      // full and overflow
      for (int k = 1; k <= 32; k++) begin
         write(32'(k));
         if (k == 24) begin
            chk("full_count24", bus.count, 3);
            chk("full_pfull24", bus.prog_full, 1);
         end
      end
      chk("full_count32", bus.count, 4);
      chk("full_flag32", bus.full, 0);
      for (int k = 33; k <= 39; k++) write(32'(k));
      chk("full_lanes7", bus.lanes, 7);
      chk("full_flag", bus.full, 1);
      chk("full_ovf_before", bus.overflow, 0);
      write(32'd40);
      chk("full_ovf", bus.overflow, 1);
      chk("full_lanes_kept", bus.lanes, 7);
      chk("full_count_kept", bus.count, 4);
      read();
      chk("full_rd0", bus.dout, pack8(32'd1));
      chk("full_cleared", bus.full, 0);
      write(32'd100);
      chk("full_recommit_count", bus.count, 4);
      chk("full_recommit_lanes", bus.lanes, 0);
      read();
      chk("full_rd1", bus.dout, pack8(32'd9));
      read();
      chk("full_rd2", bus.dout, pack8(32'd17));
      read();
      chk("full_rd3", bus.dout, pack8(32'd25));
      read();
      exp = pack8(32'd33);
      exp[31:0] = 32'd100;
      chk("full_rd4", bus.dout, exp);
      chk("full_drained", bus.empty, 1);

      // wrap with reads overlapping commits
      for (int k = 0; k < 64; k++) begin
         bus.din   = 32'h1000 + 32'(k);
         bus.wr_en = 1'b1;
         bus.rd_en = (k >= 15) && (k % 8 == 7);
         tick();
         chk("wrap_count", bus.count, (k >= 7) ? 1 : 0);
         if (bus.rd_en) begin
            chk("wrap_valid", bus.valid, 1);
            chk("wrap_dout", bus.dout, pack8(32'h1000 + 32'(8 * ((k - 15) / 8))));
         end
      end
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      read();
      chk("wrap_last", bus.dout, pack8(32'h1000 + 32'd56));
      chk("wrap_empty", bus.empty, 1);

      // deferred flush
      for (int k = 0; k < 32; k++) write(32'd200 + 32'(k));
      write(32'd300);
      write(32'd301);
      write(32'd302);
      chk("defer_lanes3", bus.lanes, 3);
      bus.flush = 1'b1;
      #1;
      chk("defer_full", bus.full, 1);
      tick();
      chk("defer_held_count", bus.count, 4);
      chk("defer_held_lanes", bus.lanes, 3);
      read();
      chk("defer_rd", bus.dout, pack8(32'd200));
      chk("defer_pop_count", bus.count, 3);
      chk("defer_pop_lanes", bus.lanes, 3);
      tick();
      bus.flush = 1'b0;
      chk("defer_commit_count", bus.count, 4);
      chk("defer_commit_lanes", bus.lanes, 0);
      read();
      read();
      read();
      chk("defer_rd3", bus.dout, pack8(32'd224));
      read();
      chk("defer_rd_pad", bus.dout, {32'd300, 32'd301, 32'd302, 160'h0});

      // asynchronous reset mid-operation
      for (int k = 0; k < 21; k++) write(32'h400 + 32'(k));
      chk("mid_count", bus.count, 2);
      chk("mid_lanes", bus.lanes, 5);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_count", bus.count, 0);
      chk("arst_lanes", bus.lanes, 0);
      chk("arst_empty", bus.empty, 1);
      chk("arst_ovf", bus.overflow, 0);
      chk("arst_dout", bus.dout, 0);
      chk("arst_pfull", bus.prog_full, 0);
      #1;
      rstn = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) write(32'h500 + 32'(k));
      chk("post_count", bus.count, 1);
      read();
      chk("post_dout", bus.dout, pack8(32'h500));
      chk("post_empty", bus.empty, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
